// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-deep request tracking against a 1-cycle BRAM,
// and a 2-entry {pc, instr} buffer feeding decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr
);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d, head_instr_q, head_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d, tail_instr_q, tail_instr_d;

  logic       pop, push;
  logic [2:0] occ;

  assign pop       = (count_q != 2'd0) & out_ready;
  assign push      = inflight_q & ~redirect;
  // Occupancy after this cycle if nothing new is issued; issue only when a slot is guaranteed.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_en   = ~rst & ~redirect & (occ <= 3'd1);
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_pc_q;
  assign out_instr = head_instr_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = imem_en;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    head_pc_d     = head_pc_q;
    head_instr_d  = head_instr_q;
    tail_pc_d     = tail_pc_q;
    tail_instr_d  = tail_instr_q;

    if (imem_en) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 32'd4;
    end

    if (redirect) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = imem_rdata;
          end else begin
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_pc_d    = tail_pc_q;
          head_instr_d = tail_instr_q;
          count_d      = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_d    = inflight_pc_q;
            head_instr_d = imem_rdata;
          end else begin
            head_pc_d    = tail_pc_q;
            head_instr_d = tail_instr_q;
            tail_pc_d    = inflight_pc_q;
            tail_instr_d = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      head_pc_q     <= 32'd0;
      head_instr_q  <= 32'd0;
      tail_pc_q     <= 32'd0;
      tail_instr_q  <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      head_instr_q  <= head_instr_d;
      tail_pc_q     <= tail_pc_d;
      tail_instr_q  <= tail_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed corner sequences, a redirect vector table,
// and a randomized phase checked against a stream-level reference model.
module tb_fetch_unit;
  localparam int AW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, redirect = 1'b0, out_ready = 1'b1;
  logic [31:0]   redirect_pc = 32'd0;
  logic          imem_en, out_valid;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0, out_pc, out_instr;

  logic          redirect2 = 1'b0, out_ready2 = 1'b1;
  logic [31:0]   redirect_pc2 = 32'd0;
  logic          imem_en2, out_valid2;
  logic [AW-1:0] imem_addr2;
  logic [31:0]   imem_rdata2 = 32'd0, out_pc2, out_instr2;

  fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr));

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(AW)) dut_wrap (
    .clk(clk), .rst(rst), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_pc(out_pc2), .out_instr(out_instr2));

  // BRAM contents: word i holds 0x1000_0000 + i
  always @(posedge clk) if (imem_en)  imem_rdata  <= 32'h1000_0000 + 32'(imem_addr);
  always @(posedge clk) if (imem_en2) imem_rdata2 <= 32'h1000_0000 + 32'(imem_addr2);

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000_0000 + {17'd0, pc[16:2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Reference model: outputs form an unbroken +4 stream from the last
  // reset/redirect target; the buffer holds at most two words.
  bit          chk_on = 1'b0;
  int          m_count = 0;
  bit          m_inf = 1'b0;
  logic [31:0] m_pc = 32'd0, m_exp = 32'd0, s_rpc = 32'd0;
  bit          s_rst = 1'b1, s_red = 1'b0, s_pop = 1'b0, s_en = 1'b0;

  always @(negedge clk) begin
    bit ev, pop, en;
    ev  = (m_count != 0);
    pop = ev && out_ready;
    en  = !rst && !redirect && ((m_count + int'(m_inf) - int'(pop)) <= 1);
    if (chk_on) begin
      chk("m_valid", 32'(out_valid), 32'(ev));
      if (ev) begin
        chk("m_pc", out_pc, m_exp);
        chk("m_instr", out_instr, instr_of(m_exp));
      end
      chk("m_imem_en", 32'(imem_en), 32'(en));
      if (en) chk("m_imem_addr", 32'(imem_addr), {17'd0, m_pc[16:2]});
      n_checks++;
      if (dut.count_q > 2'd2) begin
        n_fail++;
        $display("FAIL count_le2 at %0t: got %0d, expected <= 2", $time, dut.count_q);
      end
    end
    s_rst = rst; s_red = redirect; s_rpc = redirect_pc; s_pop = pop; s_en = en;
  end

  always @(posedge clk) begin
    if (s_rst) begin
      m_count = 0; m_inf = 1'b0; m_pc = 32'h0; m_exp = 32'h0;
    end else if (s_red) begin
      m_count = 0; m_inf = 1'b0;
      m_pc = {s_rpc[31:2], 2'b00}; m_exp = {s_rpc[31:2], 2'b00};
    end else begin
      m_count = m_count + int'(m_inf) - int'(s_pop);
      if (s_pop) m_exp = m_exp + 32'd4;
      if (s_en) m_pc = m_pc + 32'd4;
      m_inf = s_en;
    end
  end

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } redir_vec_t;

  redir_vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0040};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0080};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_7FFF};
    vecs[3] = '{32'h0000_0007, 32'h0000_0004, 32'h0000_0001};
    vecs[4] = '{32'h0002_0013, 32'h0002_0010, 32'h0000_0004};

    // Startup and PC wrap
    rst = 1'b1; out_ready = 1'b1;
    tick(); chk_on = 1'b1;
    tick(); rst = 1'b0;
    at_neg();
    chk("start_en", 32'(imem_en), 32'd1);
    chk("start_addr", 32'(imem_addr), 32'd0);
    chk("start_valid_c0", 32'(out_valid), 32'd0);
    tick(); at_neg();
    chk("start_valid_c1", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) out_ready = 1'b0;
      at_neg();
      chk("start_valid", 32'(out_valid), 32'd1);
      chk("start_pc", out_pc, 32'(4 * k));
      chk("start_instr", out_instr, 32'h1000_0000 + 32'(k));
      chk("wrap_valid", 32'(out_valid2), 32'd1);
      chk("wrap_pc", out_pc2, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("wrap_instr", out_instr2, 32'h1000_0000 + 32'((32'h7FFE + k) & 32'h7FFF));
    end

    // Backpressure, cycles 5..10
    for (int c = 5; c <= 10; c++) begin
      if (c > 5) begin tick(); at_neg(); end
      chk("bp_en", 32'(imem_en), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_pc", out_pc, 32'd12);
      chk("bp_hold_instr", out_instr, 32'h1000_0003);
    end
    tick(); out_ready = 1'b1;
    for (int c = 11; c <= 14; c++) begin
      if (c > 11) tick();
      at_neg();
      chk("bp_resume_pc", out_pc, 32'(12 + 4 * (c - 11)));
    end

    // Redirect vector table
    foreach (vecs[i]) begin
      tick(); redirect = 1'b1; redirect_pc = vecs[i].rpc;
      at_neg();
      chk("rd_en_t", 32'(imem_en), 32'd0);
      tick(); redirect = 1'b0;
      at_neg();
      chk("rd_en_t1", 32'(imem_en), 32'd1);
      chk("rd_addr_t1", 32'(imem_addr), vecs[i].exp_addr);
      chk("rd_valid_t1", 32'(out_valid), 32'd0);
      tick(); at_neg();
      chk("rd_valid_t2", 32'(out_valid), 32'd0);
      tick(); at_neg();
      chk("rd_valid_t3", 32'(out_valid), 32'd1);
      chk("rd_pc_t3", out_pc, vecs[i].exp_pc);
      chk("rd_instr_t3", out_instr, instr_of(vecs[i].exp_pc));
      tick(); at_neg();
      chk("rd_pc_t4", out_pc, vecs[i].exp_pc + 32'd4);
    end

    // Redirect while stalled with a full buffer
    tick(); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    at_neg();
    chk("rs_full_valid", 32'(out_valid), 32'd1);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0200;
    at_neg();
    chk("rs_en_t", 32'(imem_en), 32'd0);
    tick(); redirect = 1'b0; out_ready = 1'b1;
    at_neg();
    chk("rs_valid_t1", 32'(out_valid), 32'd0);
    tick(); at_neg();
    chk("rs_valid_t2", 32'(out_valid), 32'd0);
    tick(); at_neg();
    chk("rs_valid_t3", 32'(out_valid), 32'd1);
    chk("rs_pc_t3", out_pc, 32'h0000_0200);

    // Reset mid-operation
    tick(); out_ready = 1'b0;
    tick();
    tick(); rst = 1'b1;
    at_neg();
    chk("mr_en_rst", 32'(imem_en), 32'd0);
    tick(); rst = 1'b0; out_ready = 1'b1;
    at_neg();
    chk("mr_valid_c0", 32'(out_valid), 32'd0);
    chk("mr_en_c0", 32'(imem_en), 32'd1);
    chk("mr_addr_c0", 32'(imem_addr), 32'd0);
    tick(); at_neg();
    chk("mr_valid_c1", 32'(out_valid), 32'd0);
    tick(); at_neg();
    chk("mr_valid_c2", 32'(out_valid), 32'd1);
    chk("mr_pc_c2", out_pc, 32'd0);
    chk("mr_instr_c2", out_instr, 32'h1000_0000);
    tick(); at_neg();
    chk("mr_pc_c3", out_pc, 32'd4);

    // Randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      int r;
      tick();
      r = $urandom_range(0, 99);
      rst         = (r < 1);
      redirect    = (r >= 1 && r < 6);
      redirect_pc = $urandom;
      out_ready   = ($urandom_range(0, 9) < 7);
    end
    tick(); rst = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    tick(); tick();
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
